// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back controller.
// Entry layout, source tags and arbitration constants.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int AW         = 5;
  localparam int STARVE_LIM = 2;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } entry_t;

  typedef enum logic {
    SRC_ALU,
    SRC_LD
  } src_t;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } fwd_t;

endpackage

// File: rtl/regfile_wb_if.sv
// Bundle between the execute/load paths, the register file
// write port and the operand-fetch forwarding taps.
interface regfile_wb_if;
  import wb_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            we3;
  logic [AW-1:0]   ar3;
  logic [XLEN-1:0] r3;
  logic [AW-1:0]   ar1;
  logic [AW-1:0]   ar2;
  logic            fwd1_hit;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd1_data;
  logic [XLEN-1:0] fwd2_data;
  logic            busy;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output ar1, ar2,
    input  alu_ready, ld_ready,
    input  we3, ar3, r3,
    input  fwd1_hit, fwd2_hit,
    input  fwd1_data, fwd2_data,
    input  busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  ar1, ar2,
    output alu_ready, ld_ready,
    output we3, ar3, r3,
    output fwd1_hit, fwd2_hit,
    output fwd1_data, fwd2_data,
    output busy
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order write queue; exposes every slot youngest-first
// so the forwarding search can see pending writes.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  entry_t               i_ent,
  input  logic                 i_pop,
  output entry_t               o_head,
  output logic [CW-1:0]        o_count,
  output entry_t [DEPTH-1:0]   o_ent,
  output logic   [DEPTH-1:0]   o_vld
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  entry_t        r_mem [DEPTH];
  logic          w_pop;

  assign w_pop = i_pop && (r_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset; validity comes from r_cnt.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_ent;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_comb begin
    logic [PW-1:0] w_idx;
    w_idx = '0;
    o_ent = '0;
    o_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx    = r_wr - PW'(i + 1);
      o_ent[i] = r_mem[w_idx];
      o_vld[i] = CW'(i) < r_cnt;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Register-file write-back controller: arbitrates ALU/load,
// queues writes, retires one per cycle and forwards pending data.
module regfile_wb
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  regfile_wb_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]         r_starve;
  logic               r_we3;
  logic [AW-1:0]      r_ar3;
  logic [XLEN-1:0]    r_r3;

  logic               w_force;
  logic               w_space;
  logic               w_ld_gnt;
  logic               w_alu_gnt;
  logic               w_ld_acc;
  logic               w_alu_acc;
  logic               w_push;
  logic               w_pop;
  src_t               w_src;
  entry_t             w_ent;
  entry_t             w_head;
  logic [CW-1:0]      w_cnt;
  entry_t [DEPTH-1:0] w_q;
  logic   [DEPTH-1:0] w_qv;
  fwd_t               w_f1;
  fwd_t               w_f2;

  // Load wins unless the ALU has been passed over too long.
  assign w_force   = r_starve >= 2'(STARVE_LIM);
  assign w_space   = w_cnt < CW'(DEPTH);
  assign w_ld_gnt  = !w_force;
  assign w_alu_gnt = w_force || !bus.ld_valid;

  assign bus.ld_ready  = w_space && w_ld_gnt;
  assign bus.alu_ready = w_space && w_alu_gnt;

  assign w_ld_acc  = bus.ld_valid && bus.ld_ready;
  assign w_alu_acc = bus.alu_valid && bus.alu_ready;

  assign w_src = w_ld_acc ? SRC_LD : SRC_ALU;

  always_comb begin
    w_ent = '0;
    unique case (1'b1)
      (w_src == SRC_LD):  w_ent = '{rd: bus.ld_rd,  data: bus.ld_data};
      (w_src == SRC_ALU): w_ent = '{rd: bus.alu_rd, data: bus.alu_data};
      default:            w_ent = '0;
    endcase
  end

  // x0 writes complete the handshake but are dropped here.
  assign w_push = (w_ld_acc || w_alu_acc) && (w_ent.rd != '0);
  assign w_pop  = w_cnt != '0;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_ent   (w_ent),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_cnt),
    .o_ent   (w_q),
    .o_vld   (w_qv)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (!bus.alu_valid || w_alu_acc) begin
      r_starve <= '0;
    end else if (!w_alu_gnt && r_starve < 2'(STARVE_LIM)) begin
      r_starve <= r_starve + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we3 <= 1'b0;
      r_ar3 <= '0;
      r_r3  <= '0;
    end else begin
      r_we3 <= w_pop;
      if (w_pop) begin
        r_ar3 <= w_head.rd;
        r_r3  <= w_head.data;
      end
    end
  end

  assign bus.we3  = r_we3;
  assign bus.ar3  = r_ar3;
  assign bus.r3   = r_r3;
  assign bus.busy = (w_cnt != '0) || r_we3;

  // Output stage first, then oldest to youngest: last match wins.
  function automatic fwd_t lookup(
    input logic [AW-1:0]    a,
    input entry_t [DEPTH-1:0] q,
    input logic [DEPTH-1:0] qv,
    input logic             we,
    input logic [AW-1:0]    oar,
    input logic [XLEN-1:0]  odat
  );
    fwd_t f;
    f = '0;
    if (a != '0) begin
      if (we && oar == a) f = '{hit: 1'b1, data: odat};
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (qv[i] && q[i].rd == a) f = '{hit: 1'b1, data: q[i].data};
      end
    end
    return f;
  endfunction

  assign w_f1 = lookup(bus.ar1, w_q, w_qv, r_we3, r_ar3, r_r3);
  assign w_f2 = lookup(bus.ar2, w_q, w_qv, r_we3, r_ar3, r_r3);

  assign bus.fwd1_hit  = w_f1.hit;
  assign bus.fwd1_data = w_f1.data;
  assign bus.fwd2_hit  = w_f2.hit;
  assign bus.fwd2_data = w_f2.data;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed vector bench for regfile_wb: per-cycle expected
// outputs plus a mid-operation reset sequence.
module tb_regfile_wb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_if bus ();

  regfile_wb #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic [4:0]  e_ar3;
    logic [31:0] e_r3;
    logic        e_busy;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
    input logic [4:0] a1, input logic [4:0] a2,
    input logic e_ar, input logic e_lr,
    input logic e_we, input logic [4:0] e_ar3, input logic [31:0] e_r3,
    input logic e_busy,
    input logic e_h1, input logic [31:0] e_d1,
    input logic e_h2, input logic [31:0] e_d2
  );
    vec_t v;
    v = '{av, ard, adat, lv, lrd, ldat, a1, a2, e_ar, e_lr,
          e_we, e_ar3, e_r3, e_busy, e_h1, e_d1, e_h2, e_d2};
    return v;
  endfunction

  task automatic chk(input int r, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h want %h", r, nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
    input logic [4:0] a1, input logic [4:0] a2
  );
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adat;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ldat;
    bus.ar1       = a1;
    bus.ar2       = a2;
  endtask

  task automatic chk_out(input int r, input logic we, input logic [4:0] ar3,
                         input logic [31:0] r3, input logic busy);
    n_vec++;
    chk(r, "we3",  32'(bus.we3),  32'(we));
    chk(r, "ar3",  32'(bus.ar3),  32'(ar3));
    chk(r, "r3",   bus.r3,        r3);
    chk(r, "busy", 32'(bus.busy), 32'(busy));
  endtask

  initial begin
    // av ard adat | lv lrd ldat | a1 a2 | alu_rdy ld_rdy | we ar3 r3 | busy | h1 d1 h2 d2
    vq.push_back(mk(0,0,0,            0,0,0,     0,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vq.push_back(mk(1,5,'hDEADBEEF,   0,0,0,     5,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vq.push_back(mk(0,0,0,            0,0,0,     5,0,  1,1, 0,0,0,             1, 1,'hDEADBEEF,0,0));
    vq.push_back(mk(0,0,0,            0,0,0,     5,0,  1,1, 1,5,'hDEADBEEF,    1, 1,'hDEADBEEF,0,0));
    vq.push_back(mk(0,0,0,            0,0,0,     5,0,  1,1, 0,5,'hDEADBEEF,    0, 0,0,0,0));
    vq.push_back(mk(1,7,'h77,         1,1,'h10,  0,0,  0,1, 0,5,'hDEADBEEF,    0, 0,0,0,0));
    vq.push_back(mk(1,7,'h77,         1,2,'h11,  1,0,  0,1, 0,5,'hDEADBEEF,    1, 1,'h10,0,0));
    vq.push_back(mk(1,7,'h77,         1,3,'h12,  1,0,  1,0, 1,1,'h10,          1, 1,'h10,0,0));
    vq.push_back(mk(1,7,'h77,         1,3,'h12,  7,0,  0,1, 1,2,'h11,          1, 1,'h77,0,0));
    vq.push_back(mk(0,0,0,            0,0,0,     7,3,  1,1, 1,7,'h77,          1, 1,'h77,1,'h12));
    vq.push_back(mk(0,0,0,            0,0,0,     0,3,  1,1, 1,3,'h12,          1, 0,0,1,'h12));
    vq.push_back(mk(0,0,0,            0,0,0,     0,3,  1,1, 0,3,'h12,          0, 0,0,0,0));
    vq.push_back(mk(0,0,0,            1,3,'hA,   0,0,  0,1, 0,3,'h12,          0, 0,0,0,0));
    vq.push_back(mk(0,0,0,            1,3,'hB,   3,0,  0,1, 0,3,'h12,          1, 1,'hA,0,0));
    vq.push_back(mk(0,0,0,            0,0,0,     3,0,  1,1, 1,3,'hA,           1, 1,'hB,0,0));
    vq.push_back(mk(0,0,0,            0,0,0,     3,0,  1,1, 1,3,'hB,           1, 1,'hB,0,0));
    vq.push_back(mk(0,0,0,            0,0,0,     3,0,  1,1, 0,3,'hB,           0, 0,0,0,0));
    vq.push_back(mk(1,0,'h55,         0,0,0,     0,0,  1,1, 0,3,'hB,           0, 0,0,0,0));
    vq.push_back(mk(0,0,0,            0,0,0,     0,0,  1,1, 0,3,'hB,           0, 0,0,0,0));
    vq.push_back(mk(0,0,0,            0,0,0,     3,0,  1,1, 0,3,'hB,           0, 0,0,0,0));
    vq.push_back(mk(0,0,0,            1,8,'h80,  0,0,  0,1, 0,3,'hB,           0, 0,0,0,0));
    vq.push_back(mk(0,0,0,            1,9,'h81,  0,0,  0,1, 0,3,'hB,           1, 0,0,0,0));
    vq.push_back(mk(0,0,0,            1,10,'h82, 9,8,  0,1, 1,8,'h80,          1, 1,'h81,1,'h80));
    vq.push_back(mk(0,0,0,            0,0,0,     10,9, 1,1, 1,9,'h81,          1, 1,'h82,1,'h81));
    vq.push_back(mk(0,0,0,            0,0,0,     10,0, 1,1, 1,10,'h82,         1, 1,'h82,0,0));
    vq.push_back(mk(0,0,0,            0,0,0,     10,0, 1,1, 0,10,'h82,         0, 0,0,0,0));

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vq[r]) begin
      @(negedge clk);
      drive(vq[r].av, vq[r].ard, vq[r].adat,
            vq[r].lv, vq[r].lrd, vq[r].ldat, vq[r].a1, vq[r].a2);
      #1;
      chk_out(r, vq[r].e_we, vq[r].e_ar3, vq[r].e_r3, vq[r].e_busy);
      chk(r, "alu_ready", 32'(bus.alu_ready), 32'(vq[r].e_ar));
      chk(r, "ld_ready",  32'(bus.ld_ready),  32'(vq[r].e_lr));
      chk(r, "fwd1_hit",  32'(bus.fwd1_hit),  32'(vq[r].e_h1));
      chk(r, "fwd1_data", bus.fwd1_data,      vq[r].e_d1);
      chk(r, "fwd2_hit",  32'(bus.fwd2_hit),  32'(vq[r].e_h2));
      chk(r, "fwd2_data", bus.fwd2_data,      vq[r].e_d2);
    end

    // Reset while a write is retiring and another is queued.
    @(negedge clk); drive(0, 0, 0, 1, 4, 'h44, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1, 5, 'h55, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1, 6, 'h66, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 6, 5);
    #1;
    chk_out(100, 1, 5, 'h55, 1);
    chk(100, "fwd1_hit",  32'(bus.fwd1_hit), 1);
    chk(100, "fwd1_data", bus.fwd1_data,     'h66);
    #2 rst = 1'b0;
    #1;
    chk_out(101, 0, 0, 0, 0);
    chk(101, "fwd1_hit", 32'(bus.fwd1_hit), 0);
    chk(101, "fwd2_hit", 32'(bus.fwd2_hit), 0);
    @(negedge clk);
    #1;
    chk_out(102, 0, 0, 0, 0);
    rst = 1'b1;

    @(negedge clk); drive(0, 0, 0, 1, 9, 'h99, 9, 6);
    #1;
    chk_out(103, 0, 0, 0, 0);
    chk(103, "ld_ready", 32'(bus.ld_ready), 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 9, 6);
    #1;
    chk_out(104, 0, 0, 0, 1);
    chk(104, "fwd1_data", bus.fwd1_data,     'h99);
    chk(104, "fwd2_hit",  32'(bus.fwd2_hit), 0);
    @(negedge clk);
    #1;
    chk_out(105, 1, 9, 'h99, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 6, 0);
    #1;
    chk_out(106, 0, 9, 'h99, 0);
    chk(106, "fwd1_hit", 32'(bus.fwd1_hit), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
